// File: rtl/pwm_demod_pkg.sv
// Shared constants, FSM encoding and sign-magnitude packing for the PWM
// demodulator.
package pwm_demod_pkg;

  localparam int CNT_W_DEFAULT = 12;
  localparam int SM_W          = 24;
  localparam int SM_SIGN       = 23;
  localparam int MAG_W         = SM_SIGN;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    MEASURE   = 1'b1
  } state_e;

  // A zero magnitude is always reported as positive zero.
  function automatic logic [SM_W-1:0] sm_pack(input logic neg, input logic [MAG_W-1:0] mag);
    logic sign;
    sign = neg & (mag != {MAG_W{1'b0}});
    return {sign, mag};
  endfunction

endpackage

// File: rtl/pwm_demod_ch.sv
// One phase of the demodulator: gate synchronizer, high-time counter,
// rising-edge counter and duty-to-voltage conversion register.
module pwm_demod_ch
  import pwm_demod_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pwm_i,
  input  logic            restart_i,
  input  logic            run_i,
  input  logic            latch_i,
  output logic [SM_W-1:0] u_o,
  output logic            perr_o
);

  localparam int SHIFT = MAG_W - 1 - CNT_W;
  localparam logic [CNT_W+1:0] P_EXT   = {2'b01, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0]   HIGH_ONE = {{CNT_W{1'b0}}, 1'b1};

  logic            meta_q, meta_d;
  logic            pwm_s_q, pwm_s_d;
  logic            pwm_prev_q, pwm_prev_d;
  logic [CNT_W:0]  high_q, high_d;
  logic [1:0]      edge_q, edge_d;
  logic [SM_W-1:0] u_q, u_d;
  logic            perr_q, perr_d;

  logic             rise;
  logic [CNT_W+1:0] h_x2;
  logic [CNT_W+1:0] diff;
  logic             neg;
  logic [MAG_W-1:0] mag;

  always_comb begin
    meta_d     = pwm_i;
    pwm_s_d    = meta_q;
    pwm_prev_d = pwm_s_q;
  end

  // The sample taken on the restart cycle is the first sample of the new window.
  always_comb begin
    rise   = pwm_s_q & ~pwm_prev_q;
    high_d = high_q;
    edge_d = edge_q;
    if (restart_i) begin
      high_d = {{CNT_W{1'b0}}, pwm_s_q};
      edge_d = {1'b0, rise};
    end else if (run_i) begin
      if (pwm_s_q) begin
        high_d = high_q + HIGH_ONE;
      end else begin
        high_d = high_q;
      end
      if (rise && !edge_q[1]) begin
        edge_d = edge_q + 2'd1;
      end else begin
        edge_d = edge_q;
      end
    end else begin
      high_d = high_q;
      edge_d = edge_q;
    end
  end

  // d = 2h - P, evaluated as an unsigned difference plus a sign flag.
  always_comb begin
    h_x2 = {high_q, 1'b0};
    neg  = (h_x2 < P_EXT);
    if (neg) begin
      diff = P_EXT - h_x2;
    end else begin
      diff = h_x2 - P_EXT;
    end
    mag = MAG_W'(diff) << SHIFT;
    if (latch_i) begin
      u_d    = sm_pack(neg, mag);
      perr_d = edge_q[1];
    end else begin
      u_d    = u_q;
      perr_d = perr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= 1'b0;
      pwm_s_q    <= 1'b0;
      pwm_prev_q <= 1'b0;
      high_q     <= {(CNT_W+1){1'b0}};
      edge_q     <= 2'd0;
      u_q        <= {SM_W{1'b0}};
      perr_q     <= 1'b0;
    end else begin
      meta_q     <= meta_d;
      pwm_s_q    <= pwm_s_d;
      pwm_prev_q <= pwm_prev_d;
      high_q     <= high_d;
      edge_q     <= edge_d;
      u_q        <= u_d;
      perr_q     <= perr_d;
    end
  end

  assign u_o    = u_q;
  assign perr_o = perr_q;

endmodule

// File: rtl/pwm_demod.sv
// Three-phase PWM demodulator: measures gate high time over each carrier
// period and reports it as a signed phase voltage.
module pwm_demod
  import pwm_demod_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sync_in,
  input  logic        pwm_a,
  input  logic        pwm_b,
  input  logic        pwm_c,
  output logic [23:0] Ua,
  output logic [23:0] Ub,
  output logic [23:0] Uc,
  output logic        valid,
  output logic        period_err,
  output logic [2:0]  pulse_err
);

  localparam logic [CNT_W:0] WIN_ONE = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] WIN_P   = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0] WIN_OVF = {1'b1, {(CNT_W-1){1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [CNT_W:0] win_q, win_d;
  logic           sync_meta_q, sync_meta_d;
  logic           sync_d_q, sync_d_d;
  logic           valid_q, valid_d;
  logic           period_err_q, period_err_d;

  logic           restart;
  logic           latch;
  logic           run;
  logic           perr_a, perr_b, perr_c;

  // sync_in gets the same two-flop delay as the gate synchronizers.
  always_comb begin
    sync_meta_d = sync_in;
    sync_d_d    = sync_meta_q;
  end

  // A sync arriving on the overflow cycle is handled as a window close.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    restart      = 1'b0;
    latch        = 1'b0;
    period_err_d = 1'b0;
    case (state_q)
      WAIT_SYNC: begin
        if (sync_d_q) begin
          state_d = MEASURE;
          win_d   = WIN_ONE;
          restart = 1'b1;
        end else begin
          state_d = WAIT_SYNC;
        end
      end
      MEASURE: begin
        if (sync_d_q) begin
          restart = 1'b1;
          win_d   = WIN_ONE;
          if (win_q == WIN_P) begin
            latch = 1'b1;
          end else begin
            period_err_d = 1'b1;
          end
        end else if (win_q == WIN_OVF) begin
          period_err_d = 1'b1;
          state_d      = WAIT_SYNC;
          win_d        = {(CNT_W+1){1'b0}};
        end else begin
          win_d = win_q + WIN_ONE;
        end
      end
      default: begin
        state_d = WAIT_SYNC;
      end
    endcase
    run     = (state_q == MEASURE);
    valid_d = latch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_SYNC;
      win_q        <= {(CNT_W+1){1'b0}};
      sync_meta_q  <= 1'b0;
      sync_d_q     <= 1'b0;
      valid_q      <= 1'b0;
      period_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      sync_meta_q  <= sync_meta_d;
      sync_d_q     <= sync_d_d;
      valid_q      <= valid_d;
      period_err_q <= period_err_d;
    end
  end

  pwm_demod_ch #(.CNT_W(CNT_W)) u_ch_a (
    .clk       (clk),
    .rst       (rst),
    .pwm_i     (pwm_a),
    .restart_i (restart),
    .run_i     (run),
    .latch_i   (latch),
    .u_o       (Ua),
    .perr_o    (perr_a)
  );

  pwm_demod_ch #(.CNT_W(CNT_W)) u_ch_b (
    .clk       (clk),
    .rst       (rst),
    .pwm_i     (pwm_b),
    .restart_i (restart),
    .run_i     (run),
    .latch_i   (latch),
    .u_o       (Ub),
    .perr_o    (perr_b)
  );

  pwm_demod_ch #(.CNT_W(CNT_W)) u_ch_c (
    .clk       (clk),
    .rst       (rst),
    .pwm_i     (pwm_c),
    .restart_i (restart),
    .run_i     (run),
    .latch_i   (latch),
    .u_o       (Uc),
    .perr_o    (perr_c)
  );

  assign valid      = valid_q;
  assign period_err = period_err_q;
  assign pulse_err  = {perr_c, perr_b, perr_a};

endmodule

// File: tb/tb_pwm_demod.sv
// Bench for pwm_demod: directed window table, randomized windows against a
// window-level reference model, overflow and mid-window reset sequences.
module tb_pwm_demod;

  localparam int CNT_W = 12;
  localparam int P     = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync_in;
  logic        pwm_a, pwm_b, pwm_c;
  logic [23:0] Ua, Ub, Uc;
  logic        valid, period_err;
  logic [2:0]  pulse_err;

  always #5 clk = ~clk;

  pwm_demod #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sync_in    (sync_in),
    .pwm_a      (pwm_a),
    .pwm_b      (pwm_b),
    .pwm_c      (pwm_c),
    .Ua         (Ua),
    .Ub         (Ub),
    .Uc         (Uc),
    .valid      (valid),
    .period_err (period_err),
    .pulse_err  (pulse_err)
  );

  // A phase waveform inside a window: high on [s0,e0) and on [s1,e1).
  typedef struct packed {
    logic [15:0] s0, e0, s1, e1;
  } ph_t;

  typedef struct packed {
    logic [15:0] len;
    ph_t         pa, pb, pc;
    logic        ev;
    logic [23:0] ua, ub, uc;
    logic [2:0]  pe;
  } vec_t;

  typedef struct packed {
    logic        valid;
    logic        perr;
    logic [23:0] ua, ub, uc;
    logic [2:0]  pe;
  } ev_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  ev_t         pipe[$];
  logic [2:0]  win[$];
  logic        in_win;
  logic [2:0]  last_lvl, pre_lvl;
  logic [23:0] exp_ua, exp_ub, exp_uc;
  logic        ovr_en;
  vec_t        ovr;

  function automatic ph_t ph(input int s0, input int e0, input int s1, input int e1);
    return '{16'(s0), 16'(e0), 16'(s1), 16'(e1)};
  endfunction

  function automatic logic lvl_of(input ph_t p, input int k);
    return (k >= int'(p.s0) && k < int'(p.e0)) || (k >= int'(p.s1) && k < int'(p.e1));
  endfunction

  function automatic logic [23:0] sm_of(input int h);
    int d;
    int m;
    d = 2 * h - P;
    m = ((d < 0) ? -d : d) * (1 << (22 - CNT_W));
    return (d < 0) ? (24'h800000 | 24'(m)) : 24'(m);
  endfunction

  // Summarise the recorded window: high time, rising edges, length.
  function automatic ev_t close_window();
    ev_t        e;
    int         h[3];
    int         edges[3];
    logic [2:0] prev;
    e    = '0;
    prev = pre_lvl;
    for (int j = 0; j < 3; j++) begin
      h[j]     = 0;
      edges[j] = 0;
    end
    foreach (win[k]) begin
      for (int j = 0; j < 3; j++) begin
        if (win[k][j]) h[j]++;
        if (win[k][j] && !prev[j]) edges[j]++;
      end
      prev = win[k];
    end
    e.valid = (win.size() == P);
    e.perr  = (win.size() != P);
    e.ua    = sm_of(h[0]);
    e.ub    = sm_of(h[1]);
    e.uc    = sm_of(h[2]);
    e.pe    = {edges[2] >= 2, edges[1] >= 2, edges[0] >= 2};
    return e;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_cycle(input logic s, input logic [2:0] lvl);
    ev_t e;
    ev_t old;
    @(posedge clk);
    #1;
    sync_in = s;
    {pwm_c, pwm_b, pwm_a} = lvl;
    e = '0;
    if (s) begin
      if (in_win) begin
        e = close_window();
        if (ovr_en) begin
          e.valid = ovr.ev;
          e.perr  = !ovr.ev;
          e.ua    = ovr.ua;
          e.ub    = ovr.ub;
          e.uc    = ovr.uc;
          e.pe    = ovr.pe;
          ovr_en  = 1'b0;
        end
      end
      in_win  = 1'b1;
      pre_lvl = last_lvl;
      win.delete();
      win.push_back(lvl);
    end else if (in_win) begin
      if (win.size() == P + 1) begin
        e.perr = 1'b1;
        in_win = 1'b0;
        win.delete();
      end else begin
        win.push_back(lvl);
      end
    end
    last_lvl = lvl;
    pipe.push_back(e);
    old = pipe.pop_front();
    if (old.valid) begin
      exp_ua = old.ua;
      exp_ub = old.ub;
      exp_uc = old.uc;
    end
    @(negedge clk);
    check("ctrl", 72'({valid, period_err}), 72'({old.valid, old.perr}));
    check("data", {Ua, Ub, Uc}, {exp_ua, exp_ub, exp_uc});
    if (old.valid) check("pulse_err", 72'(pulse_err), 72'(old.pe));
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #1;
    rst     = 1'b1;
    sync_in = 1'b0;
    {pwm_c, pwm_b, pwm_a} = 3'b000;
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 72'({valid, period_err}), 72'(0));
    check("rst_data", {Ua, Ub, Uc}, 72'(0));
    check("rst_pulse_err", 72'(pulse_err), 72'(0));
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_win   = 1'b0;
    win.delete();
    last_lvl = 3'b000;
    pre_lvl  = 3'b000;
    exp_ua   = 24'h000000;
    exp_ub   = 24'h000000;
    exp_uc   = 24'h000000;
    ovr_en   = 1'b0;
    pipe.delete();
    repeat (3) pipe.push_back('0);
  endtask

  initial begin
    vec_t tbl[8];
    rst     = 1'b1;
    sync_in = 1'b0;
    {pwm_c, pwm_b, pwm_a} = 3'b000;
    ovr_en  = 1'b0;
    in_win  = 1'b0;

    tbl[0] = '{16'd4096, ph(0, 3072, 0, 0), ph(0, 1024, 0, 0), ph(0, 2048, 0, 0),
               1'b1, 24'h200000, 24'hA00000, 24'h000000, 3'b000};
    tbl[1] = '{16'd4096, ph(0, 4096, 0, 0), ph(0, 0, 0, 0), ph(0, 1536, 2048, 3584),
               1'b1, 24'h400000, 24'hC00000, 24'h200000, 3'b100};
    tbl[2] = '{16'd4096, ph(0, 4096, 0, 0), ph(0, 4096, 0, 0), ph(0, 0, 0, 0),
               1'b1, 24'h400000, 24'h400000, 24'hC00000, 3'b000};
    tbl[3] = '{16'd4000, ph(0, 1536, 2000, 3536), ph(0, 0, 0, 0), ph(0, 0, 0, 0),
               1'b0, 24'h000000, 24'h000000, 24'h000000, 3'b000};
    tbl[4] = '{16'd4096, ph(0, 1536, 2048, 3584), ph(0, 2048, 0, 0), ph(1024, 3584, 0, 0),
               1'b1, 24'h200000, 24'h000000, 24'h100000, 3'b001};
    tbl[5] = '{16'd4097, ph(0, 0, 0, 0), ph(0, 0, 0, 0), ph(0, 0, 0, 0),
               1'b0, 24'h000000, 24'h000000, 24'h000000, 3'b000};
    tbl[6] = '{16'd4096, ph(4000, 4096, 0, 0), ph(0, 4096, 0, 0), ph(0, 0, 0, 0),
               1'b1, 24'hBD0000, 24'h400000, 24'hC00000, 3'b000};
    tbl[7] = '{16'd4200, ph(0, 0, 0, 0), ph(0, 0, 0, 0), ph(0, 0, 0, 0),
               1'b0, 24'h000000, 24'h000000, 24'h000000, 3'b000};

    do_reset(4);
    repeat (5) drive_cycle(1'b0, 3'b000);

    // Directed windows; the last one runs past P+1 with no sync.
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        ovr    = tbl[i-1];
        ovr_en = 1'b1;
      end
      for (int k = 0; k < int'(tbl[i].len); k++) begin
        drive_cycle(k == 0, {lvl_of(tbl[i].pc, k), lvl_of(tbl[i].pb, k), lvl_of(tbl[i].pa, k)});
      end
    end

    // Randomized windows, mostly P long with occasional near misses.
    for (int i = 0; i < 5; i++) begin
      int  len;
      int  s0, e0, s1, e1;
      ph_t r[3];
      len = ($urandom_range(0, 3) == 0) ? (P - 3 + int'($urandom_range(0, 6))) : P;
      for (int j = 0; j < 3; j++) begin
        s0   = int'($urandom_range(0, P));
        e0   = int'($urandom_range(s0, P));
        s1   = int'($urandom_range(e0, P));
        e1   = int'($urandom_range(s1, P));
        r[j] = ph(s0, e0, s1, e1);
      end
      for (int k = 0; k < len; k++) begin
        drive_cycle(k == 0, {lvl_of(r[2], k), lvl_of(r[1], k), lvl_of(r[0], k)});
      end
    end

    // Mid-window reset, then two syncs P apart are needed for a result.
    drive_cycle(1'b1, 3'b101);
    repeat (1999) drive_cycle(1'b0, 3'b101);
    do_reset(3);
    repeat (6) drive_cycle(1'b0, 3'b000);
    for (int k = 0; k < P; k++) begin
      drive_cycle(k == 0, {1'b0, k < 1024, k < 3072});
    end
    drive_cycle(1'b1, 3'b000);
    repeat (8) drive_cycle(1'b0, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_demod.md
PWM_DEMOD -- requirements
Module: pwm_demod

Interface
REQ-001 SHALL have parameter CNT_W, default 12, log2 of carrier period in clk cycles (P = 2^CNT_W); legal range 4..22.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sync_in  input  1  one-cycle pulse at the start of each carrier period, synchronous to clk.
REQ-005 SHALL have ports pwm_a, pwm_b, pwm_c  input  1 each  high-side gate signals, asynchronous to clk.
REQ-006 SHALL have ports Ua, Ub, Uc  output  24 each  reconstructed phase voltage, sign-magnitude: bit 23 = sign (1 = negative), bits 22:0 = magnitude.
REQ-007 SHALL have port valid  output  1  one-cycle pulse when Ua/Ub/Uc update.
REQ-008 SHALL have port period_err  output  1  one-cycle pulse when a measurement window is discarded for wrong length.
REQ-009 SHALL have port pulse_err  output  3  per phase {c,b,a}, set with valid when that phase had more than one rising edge in the window.

Function
REQ-010 SHALL pass each pwm_x through a 2-flop synchronizer and delay sync_in by 2 flops so all are aligned; sync_d is the delayed sync_in.
REQ-011 SHALL implement states WAIT_SYNC, MEASURE; reset enters WAIT_SYNC.
REQ-012 WAIT_SYNC: on sync_d -> MEASURE, clear window counter and all high counters; no output update.
REQ-013 MEASURE: each cycle without sync_d, window counter +1 and each high counter +1 when its synchronized pwm is 1; the sync_d cycle itself is the first sample of the new window.
REQ-014 On sync_d in MEASURE with window length exactly P: latch results, pulse valid next cycle, restart counters for the next window (stay in MEASURE).
REQ-015 On sync_d in MEASURE with window length != P: no output update, pulse period_err next cycle, restart counters, stay in MEASURE.
REQ-016 If window counter reaches P+1 with no sync_d: pulse period_err, -> WAIT_SYNC.
REQ-017 Conversion per phase, high count h in 0..P: d = 2h - P (signed, range -P..+P); magnitude = |d| << (22 - CNT_W); sign = 1 iff d < 0; d = 0 gives 24'h000000 (never negative zero).
REQ-018 Window counter and high counters SHALL be CNT_W+1 bits wide so h = P does not wrap.
REQ-019 Rising-edge detector per phase counts rising edges within the window (saturating at 2); pulse_err[x] = 1 with valid if count >= 2; an edge on the sync_d sample counts toward the new window.
REQ-020 Latency: Ua/Ub/Uc and valid update 3 clk cycles after the sync_in pulse closing a P-length window; outputs hold between updates.
REQ-021 sync_in and window overflow on the same cycle: sync_in wins (REQ-014/015 apply).

Reset
REQ-022 On rst = 1: state WAIT_SYNC; Ua = Ub = Uc = 24'h000000; valid = 0; period_err = 0; pulse_err = 3'b000; all counters, synchronizers and sync delay cleared.
REQ-023 rst mid-window SHALL discard the window; first valid after release requires two sync_in pulses P apart.

Structure
REQ-024 Shared package SHALL hold CNT_W default, 24-bit sign-magnitude width/sign-bit index and the state encoding.
REQ-025 Per-phase synchronizer, high counter, edge counter and converter SHALL be sub-module pwm_demod_ch, instantiated three times; window counter and FSM stay in pwm_demod.

Verification (CNT_W = 12, P = 4096)
REQ-026 pwm_a high 3072 of 4096 cycles per window -> Ua = 24'h200000, valid 3 cycles after closing sync_in, pulse_err[0] = 0.
REQ-027 pwm_b high 1024, pwm_c high 2048 -> Ub = 24'hA00000, Uc = 24'h000000.
REQ-028 pwm_a constantly 1 -> Ua = 24'h400000; constantly 0 -> Ua = 24'hC00000; pulse_err = 0 both cases.
REQ-029 sync_in spaced 4000 cycles -> period_err pulse, no valid, Ua unchanged; no sync_in for 4097+ cycles -> period_err, FSM in WAIT_SYNC.
REQ-030 pwm_a two pulses of 1536 cycles in one window -> Ua = 24'h200000 with pulse_err[0] = 1; rst mid-window -> all outputs 0, no valid until two sync_in pulses 4096 apart.
